// File: rtl/alu_arbiter_if.sv
// Bundle of both requester channels, the shared ALU connection and status,
// seen from the arbiter (slave) and from its surroundings (master).
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [5:0]  req0_opcode;
  logic [5:0]  req0_funct;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [5:0]  req1_opcode;
  logic [5:0]  req1_funct;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_zero;
  logic        rsp0_div0;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_zero;
  logic        rsp1_div0;
  logic [5:0]  alu_opcode;
  logic [5:0]  alu_funct;
  logic [31:0] alu_busA;
  logic [31:0] alu_busB;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;
  logic [1:0]  fsm_state;

  modport slave (
    input  req0_valid, req0_opcode, req0_funct, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_funct, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_div0,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_div0,
    input  rsp0_ready, rsp1_ready,
    output alu_opcode, alu_funct, alu_busA, alu_busB,
    input  alu_result, alu_zero,
    output busy, fsm_state
  );

  modport master (
    output req0_valid, req0_opcode, req0_funct, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_funct, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_div0,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_div0,
    output rsp0_ready, rsp1_ready,
    input  alu_opcode, alu_funct, alu_busA, alu_busB,
    output alu_result, alu_zero,
    input  busy, fsm_state
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// holding ALU inputs for an op-dependent number of cycles.
`ifndef FUNCT_ADD
`define FUNCT_ADD 6'h20
`endif
`ifndef FUNCT_SUB
`define FUNCT_SUB 6'h22
`endif
`ifndef FUNCT_MUL
`define FUNCT_MUL 6'h18
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV 6'h1a
`endif

module alu_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; valid never waits for ready, and response data stays stable while
  // valid && !ready.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        sel;
  logic [15:0] count;
  logic [15:0] lat_m1;
  logic [5:0]  opcode_q;
  logic [5:0]  funct_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        div0_q;
  logic [1:0]  rsp_valid_q;
  logic [5:0]  sel_opcode;
  logic [5:0]  sel_funct;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_mul;
  logic        sel_div;
  logic        can_accept;
  logic        accept;
  logic        rsp_ready_g;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    sel        = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    sel_opcode = sel ? bus.req1_opcode : bus.req0_opcode;
    sel_funct  = sel ? bus.req1_funct  : bus.req0_funct;
    sel_a      = sel ? bus.req1_a      : bus.req0_a;
    sel_b      = sel ? bus.req1_b      : bus.req0_b;
    sel_mul    = (sel_opcode == 6'd0) && (sel_funct == `FUNCT_MUL);
    sel_div    = (sel_opcode == 6'd0) && (sel_funct == `FUNCT_DIV);
    lat_m1     = '0;
    if (sel_mul)      lat_m1 = 16'(MUL_CYCLES - 1);
    else if (sel_div) lat_m1 = 16'(DIV_CYCLES - 1);
  end

  assign can_accept     = (state == IDLE) && !rst;
  assign bus.req0_ready = can_accept && bus.req0_valid && !sel;
  assign bus.req1_ready = can_accept && bus.req1_valid && sel;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign rsp_ready_g    = grant ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      count       <= '0;
      opcode_q    <= '0;
      funct_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      div0_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opcode_q   <= sel_opcode;
            funct_q    <= sel_funct;
            a_q        <= sel_a;
            b_q        <= sel_b;
            grant      <= sel;
            last_grant <= sel;
            count      <= lat_m1;
            div0_q     <= sel_div && (sel_b == 32'd0);
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has seen stable inputs for the full hold time here.
          if (count == 16'd0) begin
            result_q    <= bus.alu_result;
            zero_q      <= bus.alu_zero;
            rsp_valid_q <= grant ? 2'b10 : 2'b01;
            state       <= RESP;
          end else begin
            count <= count - 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready_g) begin
            rsp_valid_q <= 2'b00;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_funct   = funct_q;
  assign bus.alu_busA    = a_q;
  assign bus.alu_busB    = b_q;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = result_q;
  assign bus.rsp1_result = result_q;
  assign bus.rsp0_zero   = zero_q;
  assign bus.rsp1_zero   = zero_q;
  assign bus.rsp0_div0   = div0_q;
  assign bus.rsp1_div0   = div0_q;
  assign bus.busy        = (state != IDLE);
  assign bus.fsm_state   = state;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: drives both requesters, models the ALU and scores
// responses against an expected queue filled at accept time.
`ifndef FUNCT_ADD
`define FUNCT_ADD 6'h20
`endif
`ifndef FUNCT_SUB
`define FUNCT_SUB 6'h22
`endif
`ifndef FUNCT_MUL
`define FUNCT_MUL 6'h18
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV 6'h1a
`endif

module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [34:0] exp_q[$];
  int   grant_log[$];
  int   acc_log[$];
  logic [34:0] mon_got;
  logic [34:0] mon_exp;
  logic [31:0] alu_r;

  alu_arbiter_if bus();

  alu_arbiter #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: DIV by zero returns all ones
  always_comb begin
    alu_r = 32'h0;
    if (bus.alu_opcode == 6'd0) begin
      case (bus.alu_funct)
        `FUNCT_ADD: alu_r = bus.alu_busA + bus.alu_busB;
        `FUNCT_SUB: alu_r = bus.alu_busA - bus.alu_busB;
        `FUNCT_MUL: alu_r = bus.alu_busA * bus.alu_busB;
        `FUNCT_DIV: alu_r = (bus.alu_busB == 32'd0) ? 32'hffff_ffff : bus.alu_busA / bus.alu_busB;
        default:    alu_r = 32'h0;
      endcase
    end
    bus.alu_result = alu_r;
    bus.alu_zero   = (alu_r == 32'd0);
  end

  // scoreboard: entries are {port, div0, zero, result}
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.rsp0_valid && bus.rsp1_valid) begin
        failures++;
        $display("FAIL rsp_one_hot got=11 want=at most one valid");
      end
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        checks++;
        mon_got = {1'b0, bus.rsp0_div0, bus.rsp0_zero, bus.rsp0_result};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp0_unexpected got=%h want=none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL rsp0_data got=%h want=%h", mon_got, mon_exp);
          end
        end
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        checks++;
        mon_got = {1'b1, bus.rsp1_div0, bus.rsp1_zero, bus.rsp1_result};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp1_unexpected got=%h want=none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL rsp1_data got=%h want=%h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  // driver: raise a request and hold it until accepted; valid stays high on return
  task automatic issue(input int port, input logic [5:0] funct, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input logic ed, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_opcode = 6'd0; bus.req0_funct = funct;
      bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_opcode = 6'd0; bus.req1_funct = funct;
      bus.req1_a = a; bus.req1_b = b;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) begin
        got = 1'b1;
        acc = cyc;
        exp_q.push_back({port[0], ed, ez, er});
        grant_log.push_back(port);
        acc_log.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout port=%0d got=none want=accept", port);
    end
  endtask

  // returns at the negedge where the port's rsp_valid is first seen
  task automatic wait_rsp(input int port, output int c);
    c = -1;
    for (int i = 0; i < 40 && c < 0; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.rsp0_valid : bus.rsp1_valid) c = cyc;
    end
    checks++;
    if (c < 0) begin
      failures++;
      $display("FAIL rsp_timeout port=%0d got=none want=rsp_valid", port);
    end
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b0; bus.req0_opcode = 6'd0; bus.req0_funct = 6'd0;
    bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_opcode = 6'd0; bus.req1_funct = 6'd0;
    bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bus.req0_ready); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid got=%b%b want=00", bus.rsp0_valid, bus.rsp1_valid);
    end
    checks++;
    if ({bus.alu_opcode, bus.alu_funct, bus.alu_busA, bus.alu_busB} !== 76'd0) begin
      failures++; $display("FAIL reset_alu_inputs got=%h/%h/%h/%h want=0", bus.alu_opcode,
                           bus.alu_funct, bus.alu_busA, bus.alu_busB);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int c0, acc, c;
    c0 = cyc;
    issue(0, `FUNCT_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, acc);
    bus.req0_valid = 1'b0;
    checks++;
    if (acc !== c0) begin failures++; $display("FAIL add_first_cycle_accept got=%0d want=%0d", acc, c0); end
    wait_rsp(0, c);
    checks++;
    if (c - acc !== 2) begin failures++; $display("FAIL add_latency got=%0d want=2", c - acc); end
    checks++;
    if (bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL add_rsp1_quiet got=%b want=0", bus.rsp1_valid); end
    checks++;
    if ({bus.rsp0_zero, bus.rsp0_result} !== {1'b0, 32'd12}) begin
      failures++; $display("FAIL add_result got=%0d/%b want=12/0", bus.rsp0_result, bus.rsp0_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_mul();
    int acc, c;
    issue(1, `FUNCT_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, acc);
    bus.req1_valid = 1'b0;
    wait_rsp(1, c);
    checks++;
    if (c - acc !== 2) begin failures++; $display("FAIL sub_latency got=%0d want=2", c - acc); end
    @(posedge clk); #1;
    issue(1, `FUNCT_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, acc);
    bus.req1_valid = 1'b0;
    wait_rsp(1, c);
    checks++;
    if (c - acc !== 3) begin failures++; $display("FAIL mul_latency got=%0d want=3", c - acc); end
    checks++;
    if (bus.rsp1_result !== 32'd42) begin failures++; $display("FAIL mul_result got=%0d want=42", bus.rsp1_result); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    grant_log.delete();
    acc_log.delete();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    fork
      begin
        int acc0;
        logic [31:0] a, b, s;
        for (int k = 0; k < 3; k++) begin
          a = (k == 1) ? 32'd0 : $urandom_range(0, 100000);
          b = (k == 1) ? 32'd0 : $urandom_range(0, 100000);
          s = a + b;
          issue(0, `FUNCT_ADD, a, b, s, (s == 32'd0), 1'b0, acc0);
        end
        bus.req0_valid = 1'b0;
      end
      begin
        int acc1;
        logic [31:0] a, b, s;
        for (int k = 0; k < 3; k++) begin
          a = $urandom();
          b = $urandom();
          s = a + b;
          issue(1, `FUNCT_ADD, a, b, s, (s == 32'd0), 1'b0, acc1);
        end
        bus.req1_valid = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (grant_log.size() !== 6) begin
      failures++; $display("FAIL b2b_grant_count got=%0d want=6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] !== (i % 2)) begin
          failures++; $display("FAIL b2b_grant_order idx=%0d got=%0d want=%0d", i, grant_log[i], i % 2);
        end
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (acc_log[i] - acc_log[i-1] !== 3) begin
          failures++; $display("FAIL b2b_interval idx=%0d got=%0d want=3", i, acc_log[i] - acc_log[i-1]);
        end
      end
    end
  endtask

  task automatic test_div();
    int acc, c;
    issue(0, `FUNCT_DIV, 32'd100, 32'd0, 32'hffff_ffff, 1'b0, 1'b1, acc);
    bus.req0_valid = 1'b0;
    wait_rsp(0, c);
    checks++;
    if (c - acc !== 5) begin failures++; $display("FAIL div0_latency got=%0d want=5", c - acc); end
    checks++;
    if (bus.rsp0_div0 !== 1'b1) begin failures++; $display("FAIL div0_flag got=%b want=1", bus.rsp0_div0); end
    @(posedge clk); #1;
    issue(0, `FUNCT_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, acc);
    bus.req0_valid = 1'b0;
    wait_rsp(0, c);
    checks++;
    if (c - acc !== 5) begin failures++; $display("FAIL div_latency got=%0d want=5", c - acc); end
    checks++;
    if ({bus.rsp0_div0, bus.rsp0_result} !== {1'b0, 32'd14}) begin
      failures++; $display("FAIL div_result got=%0d/%b want=14/0", bus.rsp0_result, bus.rsp0_div0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int acc, c, rel;
    bus.rsp0_ready = 1'b0;
    issue(0, `FUNCT_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, acc);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_opcode = 6'd0; bus.req1_funct = `FUNCT_SUB;
    bus.req1_a = 32'd10; bus.req1_b = 32'd3;
    wait_rsp(0, c);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_zero, bus.rsp0_div0, bus.rsp0_result} !== {3'b100, 32'd7}) begin
        failures++; $display("FAIL stall_rsp_hold cyc=%0d got=%b/%0d want=1/7", i, bus.rsp0_valid, bus.rsp0_result);
      end
      checks++;
      if ({bus.alu_funct, bus.alu_busA, bus.alu_busB} !== {`FUNCT_ADD, 32'd3, 32'd4}) begin
        failures++; $display("FAIL stall_alu_hold cyc=%0d got=%h/%0d/%0d want=20/3/4", i,
                             bus.alu_funct, bus.alu_busA, bus.alu_busB);
      end
      checks++;
      if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL stall_req1_blocked cyc=%0d got=%b want=0", i, bus.req1_ready); end
    end
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b1;
    rel = cyc;
    issue(1, `FUNCT_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, acc);
    bus.req1_valid = 1'b0;
    checks++;
    if (acc !== rel + 1) begin failures++; $display("FAIL stall_release_accept got=%0d want=%0d", acc, rel + 1); end
    wait_rsp(1, c);
    checks++;
    if (c - acc !== 2) begin failures++; $display("FAIL stall_port1_latency got=%0d want=2", c - acc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int acc, c;
    logic [34:0] dropped;
    issue(0, `FUNCT_DIV, 32'd100, 32'd5, 32'd20, 1'b0, 1'b0, acc);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dropped = exp_q.pop_back();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
      failures++; $display("FAIL midreset_idle got=%b%b%b want=000", bus.busy, bus.rsp0_valid, bus.rsp1_valid);
    end
    checks++;
    if (bus.alu_busB !== 32'd0) begin failures++; $display("FAIL midreset_busB got=%0d want=0", bus.alu_busB); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_rsp cyc=%0d got=1 want=0", i); end
    end
    @(posedge clk); #1;
    issue(1, `FUNCT_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, acc);
    bus.req1_valid = 1'b0;
    wait_rsp(1, c);
    checks++;
    if (c - acc !== 2) begin failures++; $display("FAIL midreset_fresh_latency got=%0d want=2", c - acc); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_back_to_back();
    test_div();
    test_stall();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL queue_leftover got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
